// File: rtl/sat_pkg.sv
// sat_pkg: shared encodings, load/delete FSM states and level reduction helper for the clause array.
package sat_pkg;
  localparam logic [1:0] VAL_FREE = 2'b00;
  localparam logic [1:0] VAL_CONF = 2'b11;
  localparam logic [1:0] LIT_NONE = 2'b00;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DEL} state_t;
  function automatic logic [31:0] max(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/clause_lane.sv
// clause_lane: one literal lane of a clause row; participation, satisfaction, implication drive and reason flag.
module clause_lane
  import sat_pkg::*;
#(
  parameter int WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           lit,
  input  logic [2:0]           value,
  input  logic [2:0]           down_i,
  input  logic [WIDTH_LVL-1:0] lvl_down_i,
  input  logic [WIDTH_LVL-1:0] cmax,
  input  logic                 active,
  input  logic                 imply,
  input  logic                 mark,
  input  logic                 apply_imply,
  input  logic                 apply_bkt,
  input  logic                 clr,
  output logic                 part,
  output logic                 free,
  output logic                 sat,
  output logic                 impl_r,
  output logic                 conflict_c,
  output logic [2:0]           down_o,
  output logic [WIDTH_LVL-1:0] lvl_down_o
);
  logic       drive, first;
  logic [2:0] drv_val;
  always_comb begin
    part       = lit != LIT_NONE;
    free       = value[2:1] == VAL_FREE;
    sat        = part && lit == value[2:1];
    drive      = imply && part && free;
    drv_val    = {lit, 1'b1} | down_i;
    first      = apply_imply && drive && drv_val != down_i;
    down_o     = (drive ? drv_val : down_i) | {(mark && part) ? VAL_CONF : 2'b00, 1'b0};
    lvl_down_o = first ? cmax : lvl_down_i;
    conflict_c = active && part && impl_r && value[2:1] == VAL_CONF;
  end
  // A load wipes the reason flag even if the lane would implicate in the same cycle.
  always_ff @(posedge clk)
    if (!rst || clr) impl_r <= 1'b0;
    else if (first) impl_r <= 1'b1;
    else if (apply_bkt && part && !value[0]) impl_r <= 1'b0;
endmodule

// File: rtl/clause_row_n.sv
// clause_row_n: one clause of NUM_LITS lanes with serial load, lock-aware delete and decaying activity.
module clause_row_n
  import sat_pkg::*;
#(
  parameter int NUM_LITS  = 8,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_ACT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3*NUM_LITS-1:0]         var_value_i,
  input  logic [3*NUM_LITS-1:0]         var_value_down_i,
  output logic [3*NUM_LITS-1:0]         var_value_down_o,
  input  logic [WIDTH_LVL*NUM_LITS-1:0] var_lvl_i,
  input  logic [WIDTH_LVL*NUM_LITS-1:0] var_lvl_down_i,
  output logic [WIDTH_LVL*NUM_LITS-1:0] var_lvl_down_o,
  input  logic                          load_start_i,
  input  logic                          lit_valid_i,
  input  logic [1:0]                    lit_i,
  output logic                          lit_ready_o,
  output logic                          load_done_o,
  input  logic                          del_i,
  output logic                          del_ack_o,
  input  logic                          decay_i,
  input  logic                          apply_imply_i,
  input  logic                          apply_analyze_i,
  input  logic                          apply_bkt_i,
  output logic                          csat_o,
  output logic                          imply_o,
  output logic                          conflict_o,
  output logic [NUM_LITS-1:0]           conflict_c_o,
  output logic                          locked_o,
  output logic [WIDTH_ACT-1:0]          act_o,
  output logic [2*NUM_LITS-1:0]         lits_o
);
  localparam int IW = $clog2(NUM_LITS);
  state_t                     state, state_n;
  logic [IW-1:0]              idx;
  logic [NUM_LITS-1:0][1:0]   lit_r;
  logic [WIDTH_ACT-1:0]       act, act_inc, act_n;
  logic                       done_r;
  logic [NUM_LITS-1:0]        part, free, sat, impl, cc, nf;
  logic                       active, beat, last_beat, load_go, del_go, nfree0, nfree1, imply, mark;
  logic [WIDTH_LVL-1:0]       cmax;
  assign active    = state != ST_LOAD;
  assign beat      = state == ST_LOAD && lit_valid_i;
  assign last_beat = beat && idx == IW'(NUM_LITS - 1);
  assign load_go   = state == ST_IDLE && load_start_i;
  assign del_go    = state == ST_DEL && !(|impl);
  always_ff @(posedge clk) state <= !rst ? ST_IDLE : state_n;
  always_comb begin
    state_n = load_go ? ST_LOAD :
              (state == ST_IDLE && del_i) ? ST_DEL :
              (last_beat || del_go) ? ST_IDLE : state;
  end
  always_comb begin
    lit_ready_o  = state == ST_LOAD;
    load_done_o  = done_r;
    del_ack_o    = del_go;
    locked_o     = |impl;
    act_o        = act;
    lits_o       = lit_r;
    conflict_c_o = cc;
  end
  // Free count only needs to distinguish zero, one and many.
  always_comb begin
    nf         = part & free;
    nfree0     = nf == '0;
    nfree1     = !nfree0 && (nf & (nf - NUM_LITS'(1))) == '0;
    csat_o     = active && |sat;
    imply      = active && nfree1 && !(|sat);
    imply_o    = imply;
    conflict_o = active && |part && nfree0 && !(|sat);
    mark       = apply_analyze_i && (conflict_o || |cc);
    act_inc    = act + WIDTH_ACT'(mark && !(&act));
    act_n      = decay_i ? act_inc >> 1 : act_inc;
  end
  always_comb begin
    cmax = '0;
    for (int k = 0; k < NUM_LITS; k++)
      if (part[k] && !free[k])
        cmax = WIDTH_LVL'(max(32'(cmax), 32'(var_lvl_i[k*WIDTH_LVL +: WIDTH_LVL])));
  end
  always_ff @(posedge clk)
    if (!rst) begin
      idx    <= '0;
      lit_r  <= '0;
      act    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= last_beat;
      if (load_go) begin
        lit_r <= '0;
        act   <= '0;
        idx   <= '0;
      end else if (beat) begin
        lit_r[idx] <= lit_i;
        idx        <= idx + IW'(1);
      end else if (del_go) begin
        lit_r <= '0;
        act   <= '0;
      end else act <= act_n;
    end
  for (genvar k = 0; k < NUM_LITS; k++) begin : g_lane
    clause_lane #(.WIDTH_LVL(WIDTH_LVL)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .lit        (lit_r[k]),
      .value      (var_value_i[3*k +: 3]),
      .down_i     (var_value_down_i[3*k +: 3]),
      .lvl_down_i (var_lvl_down_i[k*WIDTH_LVL +: WIDTH_LVL]),
      .cmax       (cmax),
      .active     (active),
      .imply      (imply),
      .mark       (mark),
      .apply_imply(apply_imply_i),
      .apply_bkt  (apply_bkt_i),
      .clr        (load_go),
      .part       (part[k]),
      .free       (free[k]),
      .sat        (sat[k]),
      .impl_r     (impl[k]),
      .conflict_c (cc[k]),
      .down_o     (var_value_down_o[3*k +: 3]),
      .lvl_down_o (var_lvl_down_o[k*WIDTH_LVL +: WIDTH_LVL])
    );
  end
endmodule

// File: tb/tb_clause_row_n.sv
// tb_clause_row_n: directed stimulus with a clause-level reference model compared every cycle.
module tb_clause_row_n;
  localparam int N = 4, WL = 8, WA = 2, AMAX = 3;
  logic clk = 0, rst = 0;
  logic [3*N-1:0]  var_value_i = '0, var_value_down_i = '0, var_value_down_o;
  logic [WL*N-1:0] var_lvl_i = '0, var_lvl_down_i = '0, var_lvl_down_o;
  logic load_start_i = 0, lit_valid_i = 0, del_i = 0, decay_i = 0;
  logic apply_imply_i = 0, apply_analyze_i = 0, apply_bkt_i = 0;
  logic [1:0] lit_i = '0;
  logic lit_ready_o, load_done_o, del_ack_o, csat_o, imply_o, conflict_o, locked_o;
  logic [N-1:0] conflict_c_o;
  logic [WA-1:0] act_o;
  logic [2*N-1:0] lits_o;
  int n_cmp = 0, n_fail = 0;
  bit armed = 0;
  int m_mode = 0, m_act = 0, m_idx = 0;
  bit m_done = 0;
  logic [1:0] m_lits [N];
  logic [N-1:0] m_impl = '0;
  typedef struct {
    bit csat, imply, conf, mark;
    logic [N-1:0] cc, first;
    logic [3*N-1:0] down;
    logic [WL*N-1:0] lvl;
  } exp_t;

  clause_row_n #(.NUM_LITS(N), .WIDTH_LVL(WL), .WIDTH_ACT(WA)) dut (
    .clk(clk), .rst(rst),
    .var_value_i(var_value_i), .var_value_down_i(var_value_down_i), .var_value_down_o(var_value_down_o),
    .var_lvl_i(var_lvl_i), .var_lvl_down_i(var_lvl_down_i), .var_lvl_down_o(var_lvl_down_o),
    .load_start_i(load_start_i), .lit_valid_i(lit_valid_i), .lit_i(lit_i), .lit_ready_o(lit_ready_o),
    .load_done_o(load_done_o), .del_i(del_i), .del_ack_o(del_ack_o), .decay_i(decay_i),
    .apply_imply_i(apply_imply_i), .apply_analyze_i(apply_analyze_i), .apply_bkt_i(apply_bkt_i),
    .csat_o(csat_o), .imply_o(imply_o), .conflict_o(conflict_o), .conflict_c_o(conflict_c_o),
    .locked_o(locked_o), .act_o(act_o), .lits_o(lits_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_cmp++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
    end
  endtask

  // Clause rules evaluated on the current inputs and model state.
  function automatic exp_t eval();
    exp_t e;
    int nf = 0, fl = 0, cm = 0;
    bit on, anyp = 0, anys = 0;
    logic [1:0] pol;
    logic [2:0] d, nd;
    logic [WL-1:0] lv;
    on = m_mode != 1;
    e.cc = '0; e.first = '0; e.down = '0; e.lvl = '0;
    for (int k = 0; k < N; k++) begin
      pol = var_value_i[3*k+1 +: 2];
      if (m_lits[k] != 2'b00) begin
        anyp = 1;
        if (pol == m_lits[k]) anys = 1;
        if (pol == 2'b00) begin nf++; fl = k; end
        else if (int'(var_lvl_i[WL*k +: WL]) > cm) cm = int'(var_lvl_i[WL*k +: WL]);
        if (m_impl[k] && pol == 2'b11) e.cc[k] = on;
      end
    end
    e.csat  = on && anys;
    e.imply = on && nf == 1 && !anys;
    e.conf  = on && anyp && nf == 0 && !anys;
    e.mark  = apply_analyze_i && (e.conf || e.cc != '0);
    for (int k = 0; k < N; k++) begin
      d  = var_value_down_i[3*k +: 3];
      lv = var_lvl_down_i[WL*k +: WL];
      if (e.imply && k == fl) begin
        nd = d | {m_lits[k], 1'b1};
        if (apply_imply_i && nd != d) begin e.first[k] = 1; lv = WL'(cm); end
        d = nd;
      end
      if (e.mark && m_lits[k] != 2'b00) d = d | 3'b110;
      e.down[3*k +: 3] = d;
      e.lvl[WL*k +: WL] = lv;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit lk;
    e = eval();
    lk = |m_impl;
    if (!rst) begin
      m_mode = 0; m_impl = '0; m_act = 0; m_idx = 0; m_done = 0;
      for (int k = 0; k < N; k++) m_lits[k] = 2'b00;
    end else begin
      m_done = 0;
      for (int k = 0; k < N; k++)
        if (e.first[k]) m_impl[k] = 1;
        else if (apply_bkt_i && m_lits[k] != 2'b00 && !var_value_i[3*k]) m_impl[k] = 0;
      if (e.mark && m_act < AMAX) m_act++;
      if (decay_i) m_act = m_act / 2;
      if (m_mode == 0 && load_start_i) begin
        m_mode = 1; m_impl = '0; m_act = 0; m_idx = 0;
        for (int k = 0; k < N; k++) m_lits[k] = 2'b00;
      end else if (m_mode == 0 && del_i) m_mode = 2;
      else if (m_mode == 1 && lit_valid_i) begin
        m_lits[m_idx] = lit_i;
        if (m_idx == N - 1) begin m_mode = 0; m_done = 1; end
        m_idx++;
      end else if (m_mode == 2 && !lk) begin
        m_mode = 0; m_act = 0;
        for (int k = 0; k < N; k++) m_lits[k] = 2'b00;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    exp_t e;
    logic [2*N-1:0] el;
    e = eval();
    for (int k = 0; k < N; k++) el[2*k +: 2] = m_lits[k];
    cmp("csat", csat_o, e.csat);
    cmp("imply", imply_o, e.imply);
    cmp("conflict", conflict_o, e.conf);
    cmp("conflict_c", conflict_c_o, e.cc);
    cmp("down", var_value_down_o, e.down);
    cmp("lvl_down", var_lvl_down_o, e.lvl);
    cmp("locked", locked_o, |m_impl);
    cmp("act", act_o, m_act);
    cmp("lits", lits_o, el);
    cmp("ready", lit_ready_o, m_mode == 1);
    cmp("done", load_done_o, m_done);
    cmp("ack", del_ack_o, m_mode == 2 && m_impl == '0);
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask

  initial begin
    step(); armed = 1;
    var_value_i = {4{3'b100}};
    neg();
    cmp("t_rst_ready", lit_ready_o, 0); cmp("t_rst_act", act_o, 0);
    cmp("t_empty_conf", conflict_o, 0); cmp("t_empty_csat", csat_o, 0);
    step(); rst = 1; var_value_i = '0; var_lvl_down_i = 32'h11223344;
    load_start_i = 1; step(); load_start_i = 0;
    del_i = 1; lit_valid_i = 1; lit_i = 2'b01; neg(); cmp("t_ready", lit_ready_o, 1);
    step(); del_i = 0; lit_i = 2'b10;
    step(); lit_valid_i = 0;
    step(); lit_valid_i = 1; lit_i = 2'b00;
    step(); lit_i = 2'b01;
    step(); lit_valid_i = 0; neg();
    cmp("t_done", load_done_o, 1); cmp("t_lits", lits_o, 8'b01_00_10_01);
    step(); neg(); cmp("t_done_pulse", load_done_o, 0); cmp("t_idle", lit_ready_o, 0);
    var_value_i = {3'b000, 3'b000, 3'b010, 3'b100}; var_lvl_i = {8'd0, 8'd0, 8'd7, 8'd3};
    apply_imply_i = 1; neg();
    cmp("t_imply", imply_o, 1); cmp("t_drive3", var_value_down_o[11:9], 3'b011);
    cmp("t_lvl3", var_lvl_down_o[31:24], 7); cmp("t_lvl0", var_lvl_down_o[7:0], 8'h44);
    step(); apply_imply_i = 0; neg(); cmp("t_locked", locked_o, 1);
    step(); var_value_i[11:9] = 3'b011; neg(); cmp("t_csat", csat_o, 1); cmp("t_noimply", imply_o, 0);
    step(); var_value_i[11:9] = 3'b101; neg(); cmp("t_conflict", conflict_o, 1);
    step(); apply_analyze_i = 1; neg(); cmp("t_mark", var_value_down_o, 12'b110_000_110_110);
    step(); apply_analyze_i = 0; neg(); cmp("t_act1", act_o, 1);
    step(); del_i = 1;
    step(); del_i = 0; neg(); cmp("t_noack", del_ack_o, 0); cmp("t_lockdel", locked_o, 1);
    step(); apply_bkt_i = 1; var_value_i[11:9] = 3'b100; neg(); cmp("t_noack2", del_ack_o, 0);
    step(); apply_bkt_i = 0; neg(); cmp("t_ack", del_ack_o, 1);
    step(); neg(); cmp("t_ack_pulse", del_ack_o, 0); cmp("t_del_lits", lits_o, 0);
    step(); load_start_i = 1;
    step(); load_start_i = 0; lit_valid_i = 1; lit_i = 2'b01;
    step(); step(); lit_i = 2'b00;
    step(); step(); lit_valid_i = 0; var_value_i = {3'b000, 3'b000, 3'b100, 3'b100};
    neg(); cmp("t_act0", act_o, 0); cmp("t_conf2", conflict_o, 1);
    apply_analyze_i = 1; repeat (4) step(); apply_analyze_i = 0;
    neg(); cmp("t_act_sat", act_o, 3);
    decay_i = 1; step(); decay_i = 0; neg(); cmp("t_decay", act_o, 1);
    apply_analyze_i = 1; decay_i = 1; step(); apply_analyze_i = 0; decay_i = 0;
    neg(); cmp("t_inc_decay", act_o, 1);
    step(); load_start_i = 1;
    step(); load_start_i = 0; lit_valid_i = 1; lit_i = 2'b10;
    step(); step(); lit_valid_i = 0; rst = 0;
    step(); rst = 1; neg();
    cmp("t_mid_ready", lit_ready_o, 0); cmp("t_mid_lits", lits_o, 0); cmp("t_mid_act", act_o, 0);
    step(); neg(); cmp("t_mid_idle", lit_ready_o, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
